freq_meter: RTL and testbench

Measures the period and active-level duration of a periodic digital input, counted in `Clk` cycles. It sits at the receiving end of a divided-clock or pulse-train link, for example the output of the project's frequency dividers or an echo pulse line. It reports one measurement per input period with a single-cycle valid strobe and flags a missing signal with a timeout.

---
 rtl/freq_meter.sv | 192 +++++++++++++++++++
 tb/tb_freq_meter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: measures the period and active-level duration of a periodic input in Clk cycles.
//
// One measurement is reported per input period with a single-cycle Valid strobe. If no active
// edge arrives for TIMEOUT cycles the sticky Timeout flag is raised and the block re-arms on
// the next active edge. All state changes on the falling edge of Clk; Rst_n is synchronous.
//
// Build option:
//   FREQ_METER_SYNC_EN  defined   -> two-flop synchronizer on Sig (3-cycle latency)
//                       undefined -> single input register (2-cycle latency), for Sig on Clk
//
// Parameters:
//   CNT_SIZE   width of the period/high-time counters and outputs
//   TIMEOUT    cycles without an active edge before Timeout (must be < 2**CNT_SIZE)
//   POLARITY   active level of Sig; the active edge is the transition to this level
//
// Ports:
//   Clk        clock, logic updates on the falling edge
//   Rst_n      synchronous active-low reset
//   Sig        signal under measurement
//   Period     last measured period in cycles
//   High_time  last measured active-level duration in cycles
//   Valid      one-cycle strobe when Period/High_time update
//   Timeout    sticky no-signal flag, cleared by the next measurement

module freq_meter #(
  parameter int unsigned CNT_SIZE = 16,
  parameter int unsigned TIMEOUT  = 50000,
  parameter bit          POLARITY = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Sig,
  output logic [CNT_SIZE-1:0] Period,
  output logic [CNT_SIZE-1:0] High_time,
  output logic                Valid,
  output logic                Timeout
);

  localparam logic                IdleLevel  = ~POLARITY;
  localparam logic [CNT_SIZE-1:0] CntOne     = CNT_SIZE'(1);
  localparam logic [CNT_SIZE-1:0] CntMax     = '1;
  localparam logic [CNT_SIZE-1:0] TimeoutVal = CNT_SIZE'(TIMEOUT);

  typedef enum logic {
    StWaitEdge,
    StMeasure
  } state_e;

  state_e state_q, state_d;

  logic                s_q;       // conditioned copy of Sig
  logic                s_d_q;     // s_q delayed by one cycle
  logic                edge_det;
  logic                s_active;

  logic [CNT_SIZE-1:0] p_cnt_q, p_cnt_d;
  logic [CNT_SIZE-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_SIZE-1:0] period_q, period_d;
  logic [CNT_SIZE-1:0] high_q, high_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  // ---------------------------------------------------------------------------
  // Input conditioning. Reset values sit at the idle level so that leaving
  // reset never fabricates an edge unless Sig really is at the active level.
  // ---------------------------------------------------------------------------
`ifdef FREQ_METER_SYNC_EN
  logic sync_q;

  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      sync_q <= IdleLevel;
      s_q    <= IdleLevel;
    end else begin
      sync_q <= Sig;
      s_q    <= sync_q;
    end
  end
`else
  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      s_q <= IdleLevel;
    end else begin
      s_q <= Sig;
    end
  end
`endif

  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      s_d_q <= IdleLevel;
    end else begin
      s_d_q <= s_q;
    end
  end

  assign s_active = (s_q == POLARITY);
  assign edge_det = s_active && (s_d_q != POLARITY);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      state_q <= StWaitEdge;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    p_cnt_d   = p_cnt_q;
    h_cnt_d   = h_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    unique case (state_q)
      StWaitEdge: begin
        p_cnt_d = '0;
        h_cnt_d = '0;
        // The arming edge starts a measurement but reports nothing.
        if (edge_det) begin
          p_cnt_d = CntOne;
          h_cnt_d = CntOne;
          state_d = StMeasure;
        end
      end

      StMeasure: begin
        if (edge_det) begin
          // Edge takes priority over a coinciding timeout, so a period of
          // exactly TIMEOUT cycles is still measured.
          period_d  = p_cnt_q;
          high_d    = h_cnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          p_cnt_d   = CntOne;
          h_cnt_d   = CntOne;
        end else if (p_cnt_q == TimeoutVal) begin
          // Partial counts are dropped; the last reported values stay visible.
          timeout_d = 1'b1;
          p_cnt_d   = '0;
          h_cnt_d   = '0;
          state_d   = StWaitEdge;
        end else begin
          p_cnt_d = sat_inc(p_cnt_q);
          if (s_active) begin
            h_cnt_d = sat_inc(h_cnt_q);
          end
        end
      end

      default: begin
        state_d = StWaitEdge;
      end
    endcase
  end

  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      p_cnt_q   <= '0;
      h_cnt_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      p_cnt_q   <= p_cnt_d;
      h_cnt_q   <= h_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign Period    = period_q;
  assign High_time = high_q;
  assign Valid     = valid_q;
  assign Timeout   = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter. Three instances run side by side on one clock:
//   cfg0: CNT_SIZE=16, TIMEOUT=200, POLARITY=1
//   cfg1: CNT_SIZE=16, TIMEOUT=150, POLARITY=0
//   cfg2: CNT_SIZE=8,  TIMEOUT=255, POLARITY=1
// A reference model turns the sampled input history into expected output events (valid,
// timeout, reset) stamped with the falling-edge index on which they must appear; a monitor
// pops and compares them whenever a DUT output event occurs or one is due.

module tb_freq_meter;

  localparam int NCfg = 3;
`ifdef FREQ_METER_SYNC_EN
  localparam int Lat = 2;  // raw sample k drives the output update at edge k+2
`else
  localparam int Lat = 1;
`endif

  function automatic int cfg_cs(input int i);
    return (i == 2) ? 8 : 16;
  endfunction

  function automatic int cfg_to(input int i);
    case (i)
      0:       return 200;
      1:       return 150;
      default: return 255;
    endcase
  endfunction

  function automatic bit cfg_pol(input int i);
    return (i != 1);
  endfunction

  typedef struct {
    int m;
    bit v;
    bit t;
    int p;
    int h;
  } exp_rec_t;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic [NCfg-1:0]       sig_v, rstn_v, val_v, tout_v, done_v;
  logic [NCfg-1:0][15:0] per_a, high_a;

  // Model state
  exp_rec_t q[NCfg][$];
  bit       raw_h[NCfg][$];
  bit       rstn_h[NCfg][$];
  bit       armed[NCfg];
  bit       prev[NCfg];
  int       last_e[NCfg];
  int       act[NCfg];
  int       exp_p[NCfg];
  int       exp_h[NCfg];
  bit       exp_t[NCfg];
  int       upd      = 0;
  int       last_upd = -1;
  bit       started  = 1'b0;

  // Monitor / summary state
  int n_cmp     = 0;
  int n_fail    = 0;
  bit tprev[NCfg];
  bit drain_req = 1'b0;
  bit drained   = 1'b0;
  bit stalled   = 1'b0;

  // ---------------------------------------------------------------------------
  // DUT instances and their stimulus
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NCfg; g++) begin : g_cfg
    localparam int unsigned Cs  = cfg_cs(g);
    localparam int unsigned To  = cfg_to(g);
    localparam bit          Pol = cfg_pol(g);

    logic          sig, rst_n, valid, tout, done;
    logic [Cs-1:0] per, high;

    freq_meter #(
      .CNT_SIZE(Cs),
      .TIMEOUT (To),
      .POLARITY(Pol)
    ) u_dut (
      .Clk      (clk),
      .Rst_n    (rst_n),
      .Sig      (sig),
      .Period   (per),
      .High_time(high),
      .Valid    (valid),
      .Timeout  (tout)
    );

    assign sig_v[g]  = sig;
    assign rstn_v[g] = rst_n;
    assign val_v[g]  = valid;
    assign tout_v[g] = tout;
    assign done_v[g] = done;
    assign per_a[g]  = 16'(per);
    assign high_a[g] = 16'(high);

    task automatic level(input bit lv, input int n);
      sig = lv;
      repeat (n) @(posedge clk);
    endtask

    task automatic train(input int per_c, input int hi_c, input int n);
      for (int k = 0; k < n; k++) begin
        level(Pol, hi_c);
        level(!Pol, per_c - hi_c);
      end
    endtask

    task automatic rst_pulse(input int n);
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      rst_n = 1'b1;
    endtask

    initial begin : stim
      int unsigned r, pc, hc, nc;
      done  = 1'b0;
      rst_n = 1'b0;
      sig   = !Pol;
      repeat (3) @(posedge clk);
      rst_n = 1'b1;
      level(!Pol, 5);
      if (g == 0) begin
        train(50, 25, 5);
        train(4, 2, 6);
        train(50, 25, 3);
        level(Pol, To + 20);           // stuck active -> timeout
        level(!Pol, 10);
        train(50, 25, 3);              // restart: one arming edge, then Valid
        level(Pol, 25);
        level(!Pol, 10);
        rst_pulse(1);                  // reset mid-period, inactive phase
        level(!Pol, 14);
        train(30, 12, 4);
        train(To, To / 2, 3);          // edge coincides with timeout count
        train(To + 1, 40, 2);          // one cycle too long -> timeout every period
        level(!Pol, 5);
      end else if (g == 1) begin
        train(30, 10, 6);
      end else begin
        train(300, 150, 4);            // longer than counter range: timeouts only
        train(20, 10, 4);
      end
      for (int it = 0; it < 12; it++) begin
        r = $urandom_range(9, 0);
        if (r == 0) begin
          rst_pulse(int'($urandom_range(2, 1)));
        end else if (r == 1) begin
          level(bit'($urandom_range(1, 0)), int'($urandom_range(To + 10, 2)));
        end else begin
          pc = $urandom_range(To + 30, 4);
          hc = $urandom_range(pc - 2, 2);
          nc = $urandom_range(4, 1);
          train(int'(pc), int'(hc), int'(nc));
        end
      end
      level(!Pol, 5);
      done = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: edges are found in the input history as seen Lat edges
  // later; a measurement is the distance between consecutive edges and the
  // number of active samples between them.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    bit x, fl, ed, pol;
    for (int i = 0; i < NCfg; i++) begin
      pol = cfg_pol(i);
      raw_h[i].push_back(sig_v[i]);
      rstn_h[i].push_back(rstn_v[i]);
      if (!rstn_v[i]) begin
        armed[i] = 1'b0;
        prev[i]  = !pol;
        exp_p[i] = 0;
        exp_h[i] = 0;
        exp_t[i] = 1'b0;
        q[i].push_back('{upd, 1'b0, 1'b0, 0, 0});
      end else begin
        // Samples still in flight when a reset hit are lost and read as idle.
        x  = !pol;
        fl = 1'b0;
        if (upd >= Lat) begin
          for (int t = upd - Lat; t < upd; t++) begin
            if (!rstn_h[i][t]) fl = 1'b1;
          end
          if (!fl) x = raw_h[i][upd - Lat];
        end
        ed = (x == pol) && (prev[i] != pol);
        if (ed) begin
          if (armed[i]) begin
            exp_p[i] = upd - last_e[i];
            exp_h[i] = act[i];
            exp_t[i] = 1'b0;
            q[i].push_back('{upd, 1'b1, 1'b0, exp_p[i], exp_h[i]});
          end
          armed[i]  = 1'b1;
          last_e[i] = upd;
          act[i]    = 1;
        end else if (armed[i]) begin
          if (upd - last_e[i] == cfg_to(i)) begin
            armed[i] = 1'b0;
            exp_t[i] = 1'b1;
            q[i].push_back('{upd, 1'b0, 1'b1, exp_p[i], exp_h[i]});
          end else if (x == pol) begin
            act[i]++;
          end
        end
        prev[i] = x;
      end
    end
    started  = 1'b1;
    last_upd = upd;
    upd++;
  end

  // ---------------------------------------------------------------------------
  // Monitor: samples 1 time unit after the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_rec_t e;
    bit       trig;
    int       cur;
    #1;
    if (started) begin
      cur = last_upd;
      for (int i = 0; i < NCfg; i++) begin
        while (q[i].size() > 0 && q[i][0].m < cur) begin
          e = q[i].pop_front();
          n_cmp++;
          n_fail++;
          $display("FAIL cfg%0d missing_event at update %0d: got no output event, required valid=%0b timeout=%0b period=%0d high=%0d",
                   i, e.m, e.v, e.t, e.p, e.h);
        end
        trig = (val_v[i] === 1'b1) || ((tout_v[i] === 1'b1) && !tprev[i]) ||
               (q[i].size() > 0 && q[i][0].m == cur);
        if (trig) begin
          n_cmp++;
          if (q[i].size() == 0 || q[i][0].m != cur) begin
            n_fail++;
            $display("FAIL cfg%0d unexpected_event at update %0d: got valid=%0b timeout=%0b period=%0d high=%0d, required no event",
                     i, cur, val_v[i], tout_v[i], per_a[i], high_a[i]);
          end else begin
            e = q[i].pop_front();
            if (val_v[i] !== e.v || tout_v[i] !== e.t ||
                per_a[i] !== 16'(e.p) || high_a[i] !== 16'(e.h)) begin
              n_fail++;
              $display("FAIL cfg%0d output_event at update %0d: got valid=%0b timeout=%0b period=%0d high=%0d, required valid=%0b timeout=%0b period=%0d high=%0d",
                       i, cur, val_v[i], tout_v[i], per_a[i], high_a[i], e.v, e.t, e.p, e.h);
            end
          end
        end
        tprev[i] = (tout_v[i] === 1'b1);
      end
    end
    if (drain_req && !drained) begin
      for (int i = 0; i < NCfg; i++) begin
        n_cmp++;
        if (q[i].size() != 0) begin
          n_fail++;
          $display("FAIL cfg%0d leftover_events: got %0d pending, required 0", i, q[i].size());
        end
      end
      n_cmp++;
      if (stalled) begin
        n_fail++;
        $display("FAIL stimulus_done: got done=%b, required all set within cycle budget", done_v);
      end
      drained = 1'b1;
    end
  end

  initial begin : main
    int c;
    c = 0;
    while (done_v != '1 && c < 60000) begin
      @(posedge clk);
      c++;
    end
    stalled = (done_v != '1);
    repeat (300) @(posedge clk);
    drain_req = 1'b1;
    c = 0;
    while (!drained && c < 10) begin
      @(posedge clk);
      c++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
